// File: rtl/rr_arb_8_if.sv
// Request/grant bundle between the requesting units and the 8-way arbiter.
// The master side drives req; the slave side (the arbiter) drives the grant
// signals. timeout_o exists only when ARB_TIMEOUT_EN is defined.
interface rr_arb_8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic       timeout_o;
`endif

`ifdef ARB_TIMEOUT_EN
    modport master (output req, input gnt, input gnt_idx, input gnt_valid, input timeout_o);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output timeout_o);
`else
    modport master (output req, input gnt, input gnt_idx, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
`endif
endinterface

// File: rtl/rr_arb_8.sv
// rr_arb_8: 8-way round-robin arbiter with registered one-hot grant.
// A grant is held until its owner drops its request, and one idle cycle
// always separates consecutive grants. The search pointer moves past each
// winner, so requesters are served in rotation.
// Optional feature macro: ARB_TIMEOUT_EN -- limits a grant to MAX_HOLD cycles
// and pulses timeout_o on a forced revoke.
module rr_arb_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    rr_arb_8_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [7:0] gnt_r;
    logic [2:0] idx_r;
    logic       valid_r;
    logic [2:0] ptr;

    logic       found;
    logic [2:0] winner;
    logic [2:0] cand;

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hcnt;
    logic           tmo_r;
`endif

    // Search req starting at ptr and wrapping around; the first set bit wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Two-state grant FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_r   <= 8'h00;
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
            ptr     <= 3'd0;
`ifdef ARB_TIMEOUT_EN
            hcnt    <= '0;
            tmo_r   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            tmo_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_r   <= 8'h01 << winner;
                        idx_r   <= winner;
                        valid_r <= 1'b1;
                        ptr     <= winner + 3'd1;
                        state   <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hcnt    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.req[idx_r]) begin
                        gnt_r   <= 8'h00;
                        valid_r <= 1'b0;
                        state   <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (hcnt == HCW'(MAX_HOLD - 1)) begin
                        gnt_r   <= 8'h00;
                        valid_r <= 1'b0;
                        tmo_r   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hcnt    <= hcnt + HCW'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = idx_r;
    assign bus.gnt_valid = valid_r;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout_o = tmo_r;
`endif

endmodule
